// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID packet queue.
// The master side is the fetch/decode pair driving the queue; the slave side is the queue itself.
interface if_id_queue_if;
  logic [31:0] instruction_in;
  logic [63:0] PC_in;
  logic [63:0] PC_branch_link_in;
  logic        in_valid;
  logic        out_ready;
  logic        flush;
  logic [31:0] instruction_out;
  logic [63:0] PC_out;
  logic [63:0] PC_branch_link_out;
  logic        out_valid;
  logic        PCWrite;
  logic [1:0]  count;

  modport master (
    output instruction_in, PC_in, PC_branch_link_in, in_valid, out_ready, flush,
    input  instruction_out, PC_out, PC_branch_link_out, out_valid, PCWrite, count
  );

  modport slave (
    input  instruction_in, PC_in, PC_branch_link_in, in_valid, out_ready, flush,
    output instruction_out, PC_out, PC_branch_link_out, out_valid, PCWrite, count
  );
endinterface

// File: rtl/if_id_queue.sv
// Two-entry FIFO carrying fetch packets {instruction, PC, PC+4} from fetch to decode.
// Empty queue presents a NOP with zero PCs. Flush empties the queue at the next edge.
module if_id_queue (
  input  logic          clock,
  input  logic          reset,
  if_id_queue_if.slave  q
);
  localparam logic [31:0] NOP = 32'hD503201F;

  logic [31:0] instr_mem [2];
  logic [63:0] pc_mem    [2];
  logic [63:0] link_mem  [2];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count_r;
  logic [1:0] count_next;
  logic       not_full;
  logic       not_empty;
  logic       push;
  logic       pop;

  // Handshake qualifiers derive from registered occupancy only
  always_comb begin
    not_full  = (count_r != 2'd2);
    not_empty = (count_r != 2'd0);
    push      = q.in_valid & not_full & ~q.flush;
    pop       = not_empty & q.out_ready & ~q.flush;
    count_next = count_r;
    if (push && !pop)
      count_next = count_r + 2'd1;
    else if (pop && !push)
      count_next = count_r - 2'd1;
  end

  // Pointer and occupancy registers; flush and reset both return to the empty state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_r <= '0;
    end else if (q.flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_r <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count_r <= count_next;
    end
  end

  // Entry storage; left unreset since it is masked whenever the queue is empty
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr] <= q.instruction_in;
      pc_mem[wr_ptr]    <= q.PC_in;
      link_mem[wr_ptr]  <= q.PC_branch_link_in;
    end
  end

  // Head entry or empty-queue defaults onto the decode side
  always_comb begin
    q.out_valid = not_empty;
    q.PCWrite   = not_full;
    q.count     = count_r;
    if (not_empty) begin
      q.instruction_out    = instr_mem[rd_ptr];
      q.PC_out             = pc_mem[rd_ptr];
      q.PC_branch_link_out = link_mem[rd_ptr];
    end else begin
      q.instruction_out    = NOP;
      q.PC_out             = '0;
      q.PC_branch_link_out = '0;
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed and randomized checks of if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  localparam logic [31:0] NOP = 32'hD503201F;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
    logic [63:0] link;
  } pkt_t;

  logic clock;
  logic reset;
  if_id_queue_if bus ();

  if_id_queue dut (
    .clock (clock),
    .reset (reset),
    .q     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  pkt_t mq[$];
  int unsigned vectors;
  int unsigned miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference queue
  task automatic check_all(input string tag);
    pkt_t h;
    if (mq.size() > 0) h = mq[0];
    else begin
      h.ins = NOP; h.pc = '0; h.link = '0;
    end
    chk({tag, ".count"},     {62'd0, bus.count},      64'(mq.size()));
    chk({tag, ".out_valid"}, {63'd0, bus.out_valid},  64'(mq.size() != 0));
    chk({tag, ".PCWrite"},   {63'd0, bus.PCWrite},    64'(mq.size() != 2));
    chk({tag, ".instr"},     {32'd0, bus.instruction_out}, {32'd0, h.ins});
    chk({tag, ".PC_out"},    bus.PC_out,             h.pc);
    chk({tag, ".link"},      bus.PC_branch_link_out, h.link);
  endtask

  // Apply one cycle of inputs, advance the model, and check after the edge
  task automatic step(input logic iv, input logic ordy, input logic fl,
                      input logic [31:0] ins, input logic [63:0] pc, input string tag);
    pkt_t p;
    logic do_push, do_pop;
    bus.in_valid = iv;
    bus.out_ready = ordy;
    bus.flush = fl;
    bus.instruction_in = ins;
    bus.PC_in = pc;
    bus.PC_branch_link_in = pc + 64'd4;
    do_push = iv && (mq.size() < 2) && !fl;
    do_pop  = ordy && (mq.size() > 0) && !fl;
    @(posedge clock);
    if (fl) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        p.ins = ins; p.pc = pc; p.link = pc + 64'd4;
        mq.push_back(p);
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush = 1'b0;
    bus.instruction_in = '0;
    bus.PC_in = '0;
    bus.PC_branch_link_in = '0;
    #3;
    check_all("reset");
    @(posedge clock); #1;
    check_all("reset_hold");
    reset = 1'b1;

    // Single push with decode stalled
    step(1, 0, 0, 32'h8B020020, 64'h1000, "push1");
    step(0, 1, 0, 32'h0, 64'h0, "pop1");

    // Fill, overflow attempt while full (also with out_ready), drain
    step(1, 0, 0, 32'h11111111, 64'h1000, "fill_a");
    step(1, 0, 0, 32'h22222222, 64'h1004, "fill_b");
    step(1, 0, 0, 32'h33333333, 64'h1008, "full_ignored");
    step(1, 1, 0, 32'h44444444, 64'h100C, "full_pop_no_push");
    step(0, 1, 0, 32'h0, 64'h0, "drain");
    step(0, 1, 0, 32'h0, 64'h0, "empty_pop_ignored");

    // Simultaneous push/pop at count 1
    step(1, 0, 0, 32'hAAAA0000, 64'h2000, "head_2000");
    step(1, 1, 0, 32'hAAAA0004, 64'h2004, "pushpop");

    // Flush from full with in_valid and out_ready asserted, held two cycles
    step(1, 0, 0, 32'hBBBB0000, 64'h2008, "fill_c");
    step(1, 1, 1, 32'hBBBB0004, 64'h200C, "flush1");
    step(1, 1, 1, 32'hBBBB0008, 64'h2010, "flush2");
    step(1, 0, 0, 32'hBBBB000C, 64'h2014, "after_flush");

    // Asynchronous reset between edges while full
    step(1, 0, 0, 32'hCCCC0000, 64'h2018, "fill_d");
    #2;
    reset = 1'b0;
    mq.delete();
    #1;
    check_all("async_reset");
    @(posedge clock); #1;
    reset = 1'b1;
    step(1, 0, 0, 32'h30000000, 64'h3000, "push_3000");
    step(0, 1, 0, 32'h0, 64'h0, "pop_3000");

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      logic [63:0] pc;
      pc = {$urandom, $urandom} & ~64'h3;
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 49) == 0), $urandom, pc, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
